// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data-side memory bus between the MEM stage and the
// data memory responder.
//   master : initiator (MEM stage) drives req/memwrite/sig_write/addr/wdata
//            and observes rdata/rvalid/stall
//   slave  : responder drives rdata/rvalid/stall
// Signals:
//   req        access request valid this cycle
//   memwrite   1 = store, 0 = load
//   sig_write  byte enables for stores (bit i -> wdata[8i+7:8i])
//   addr       byte address
//   wdata      lane-aligned store data
//   rdata      full word returned by the last load
//   rvalid     one-cycle pulse when rdata was updated by a load
//   stall      access in progress, initiator holds its request stable
interface dmem_responder_if;
  logic        req;
  logic        memwrite;
  logic [3:0]  sig_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;

  modport master (
    output req, memwrite, sig_write, addr, wdata,
    input  rdata, rvalid, stall
  );

  modport slave (
    input  req, memwrite, sig_write, addr, wdata,
    output rdata, rvalid, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the MEM stage. Applies
// byte-enabled stores, returns full words for loads, and can insert
// LATENCY-1 wait states during which stall is raised to the hazard unit.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dmem_responder_if.slave (req/memwrite/sig_write/addr/wdata in,
//        rdata/rvalid/stall out)
// Parameters: DEPTH words, ADDR_W = log2(DEPTH), LATENCY >= 1.
// Optional build macro DMEM_CLEAR_ON_RST_EN: after reset, sweep zeros into
// every RAM word (one per cycle) while holding stall high.
//
// state | meaning
// IDLE  | no access pending
// WAIT  | access pending, cnt counts wait cycles up to LATENCY-1
// CLEAR | post-reset RAM zeroing sweep (DMEM_CLEAR_ON_RST_EN only)
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
`ifdef DMEM_CLEAR_ON_RST_EN
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_RESET = ST_CLEAR;
`else
  localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              commit;
  logic              stall;
  logic              unused_addr;

  // Byte offset and bits above the RAM window are don't-care; the index
  // therefore wraps modulo DEPTH.
  assign idx         = bus.addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

`ifdef DMEM_CLEAR_ON_RST_EN
  logic [ADDR_W-1:0] clr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (LATENCY == 1) begin
            commit = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
            stall   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        stall = (cnt_q != CNT_LAST);
        if (!bus.req) begin
          // initiator abandoned the access: drop it without committing
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef DMEM_CLEAR_ON_RST_EN
      ST_CLEAR: begin
        stall = 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= commit && !bus.memwrite;
      if (commit && !bus.memwrite) begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  // RAM has no reset so it maps onto block memory; contents survive rst
  // unless the clear sweep is built in.
  always_ff @(posedge clk) begin
    if (!rst && commit && bus.memwrite) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sig_write[b]) begin
          mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
`ifdef DMEM_CLEAR_ON_RST_EN
    else if (!rst && state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end
`endif
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.stall  = stall;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst1, rst3;
  int checks = 0;
  int errors = 0;

  dmem_responder_if b1();
  dmem_responder_if b3();

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1)
  );
  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(b3)
  );

  always #5 clk = ~clk;

  // Reference model: plain word arrays plus the last value a load returned.
  logic [31:0] model1 [1024];
  logic [31:0] model3 [1024];
  logic [31:0] last_rd1, last_rd3;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  // Drive one access on the LATENCY=1 DUT. Entered and left at posedge+1.
  task automatic acc1(input bit we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic rv, output logic st);
    b1.req = 1'b1; b1.memwrite = we; b1.sig_write = be; b1.addr = a; b1.wdata = wd;
    #3 st = b1.stall;
    @(posedge clk); #1;
    b1.req = 1'b0;
    rd = b1.rdata;
    rv = b1.rvalid;
  endtask

  // Drive one access on the LATENCY=3 DUT, holding it until stall is low.
  task automatic acc3(input bit we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic rv, output logic rv_next,
                      output int stalls, output bit tmo);
    bit done;
    done = 1'b0;
    stalls = 0;
    b3.req = 1'b1; b3.memwrite = we; b3.sig_write = be; b3.addr = a; b3.wdata = wd;
    for (int i = 0; i < 10 && !done; i++) begin
      #3;
      if (b3.stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    tmo = !done;
    b3.req = 1'b0;
    rd = b3.rdata;
    rv = b3.rvalid;
    @(posedge clk); #1;
    rv_next = b3.rvalid;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0;
    last_rd1 = '0; last_rd3 = '0;
    checks += 6;
    if (b1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp %h", b1.rdata, 32'h0); end
    if (b1.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid1 got %b exp 0", b1.rvalid); end
    if (b1.stall !== 1'b0) begin errors++; $display("FAIL reset_stall1 got %b exp 0", b1.stall); end
    if (b3.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got %h exp %h", b3.rdata, 32'h0); end
    if (b3.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid3 got %b exp 0", b3.rvalid); end
    if (b3.stall !== 1'b0) begin errors++; $display("FAIL reset_stall3 got %b exp 0", b3.stall); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic rv, st;
    acc1(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, rd, rv, st);
    checks += 3;
    if (rv !== 1'b0) begin errors++; $display("FAIL store_rvalid got %b exp 0", rv); end
    if (st !== 1'b0) begin errors++; $display("FAIL store_stall got %b exp 0", st); end
    if (rd !== 32'h0) begin errors++; $display("FAIL store_keeps_rdata got %h exp %h", rd, 32'h0); end
    acc1(1'b0, 4'b0000, 32'h10, 32'h0, rd, rv, st);
    checks += 3;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_full got %h exp %h", rd, 32'hDEADBEEF); end
    if (rv !== 1'b1) begin errors++; $display("FAIL load_rvalid got %b exp 1", rv); end
    if (st !== 1'b0) begin errors++; $display("FAIL load_stall got %b exp 0", st); end
    acc1(1'b1, 4'b0100, 32'h10, 32'h00AA0000, rd, rv, st);
    acc1(1'b0, 4'b1111, 32'h10, 32'h0, rd, rv, st);
    checks++;
    if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL byte_lane2 got %h exp %h", rd, 32'hDEAABEEF); end
    acc1(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, rv, st);
    acc1(1'b0, 4'b0000, 32'h10, 32'h0, rd, rv, st);
    checks++;
    if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL zero_strobe got %h exp %h", rd, 32'hDEAABEEF); end
    last_rd1 = 32'hDEAABEEF;
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic rv, st;
    acc1(1'b1, 4'b1111, 32'h00001004, 32'h12345678, rd, rv, st);
    acc1(1'b0, 4'b0000, 32'h00000004, 32'h0, rd, rv, st);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap got %h exp %h", rd, 32'h12345678); end
    last_rd1 = 32'h12345678;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic rv, st;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      acc1(1'b1, 4'b1111, 32'h200 + 32'(4 * i), vals[i], rd, rv, st);
    end
    for (int i = 0; i < 4; i++) begin
      acc1(1'b0, 4'b0000, 32'h200 + 32'(4 * i), 32'h0, rd, rv, st);
      checks += 2;
      if (rd !== vals[i]) begin errors++; $display("FAIL b2b_rdata%0d got %h exp %h", i, rd, vals[i]); end
      if (rv !== 1'b1) begin errors++; $display("FAIL b2b_rvalid%0d got %b exp 1", i, rv); end
    end
    last_rd1 = vals[3];
  endtask

  task automatic test_latency3();
    logic [31:0] rd; logic rv, rvn; int stalls; bit tmo;
    acc3(1'b1, 4'b1111, 32'h10, 32'hCAFEF00D, rd, rv, rvn, stalls, tmo);
    checks += 2;
    if (tmo || stalls != 2) begin errors++; $display("FAIL l3_store_stalls got %0d exp 2 (timeout %0d)", stalls, tmo); end
    if (rv !== 1'b0) begin errors++; $display("FAIL l3_store_rvalid got %b exp 0", rv); end
    acc3(1'b0, 4'b0000, 32'h10, 32'h0, rd, rv, rvn, stalls, tmo);
    checks += 4;
    if (tmo || stalls != 2) begin errors++; $display("FAIL l3_load_stalls got %0d exp 2 (timeout %0d)", stalls, tmo); end
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_load_rdata got %h exp %h", rd, 32'hCAFEF00D); end
    if (rv !== 1'b1) begin errors++; $display("FAIL l3_load_rvalid got %b exp 1", rv); end
    if (rvn !== 1'b0) begin errors++; $display("FAIL l3_rvalid_pulse got %b exp 0", rvn); end
    last_rd3 = 32'hCAFEF00D;
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic rv, rvn; int stalls; bit tmo;
    acc3(1'b1, 4'b1111, 32'h24, 32'h0BADF00D, rd, rv, rvn, stalls, tmo);
    b3.req = 1'b1; b3.memwrite = 1'b1; b3.sig_write = 4'b1111;
    b3.addr = 32'h24; b3.wdata = 32'h99999999;
    @(posedge clk); #1;
    b3.req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b3.rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid got %b exp 0", b3.rvalid); end
    acc3(1'b0, 4'b0000, 32'h24, 32'h0, rd, rv, rvn, stalls, tmo);
    checks += 2;
    if (tmo || stalls != 2) begin errors++; $display("FAIL abort_next_stalls got %0d exp 2 (timeout %0d)", stalls, tmo); end
    if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_no_write got %h exp %h", rd, 32'h0BADF00D); end
    last_rd3 = 32'h0BADF00D;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic rv, rvn; int stalls; bit tmo;
    acc3(1'b1, 4'b1111, 32'h20, 32'h11111111, rd, rv, rvn, stalls, tmo);
    b3.req = 1'b1; b3.memwrite = 1'b1; b3.sig_write = 4'b1111;
    b3.addr = 32'h20; b3.wdata = 32'h55555555;
    @(posedge clk); #1;
    rst3 = 1'b1; b3.req = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    last_rd3 = '0;
    checks += 3;
    if (b3.rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h exp %h", b3.rdata, 32'h0); end
    if (b3.stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b exp 0", b3.stall); end
    if (b3.rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b exp 0", b3.rvalid); end
    acc3(1'b0, 4'b0000, 32'h20, 32'h0, rd, rv, rvn, stalls, tmo);
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL midrst_no_write got %h exp %h", rd, 32'h11111111); end
    last_rd3 = 32'h11111111;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp; logic rv, rvn, st; int stalls; bit tmo;
    logic [3:0] be; bit we; int pool [8]; int w;
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(1023, 0));
      a = 32'(pool[i]) << 2;
      wd = $urandom;
      acc1(1'b1, 4'b1111, a, wd, rd, rv, st);
      model1[pool[i]] = wd;
      wd = $urandom;
      acc3(1'b1, 4'b1111, a, wd, rd, rv, rvn, stalls, tmo);
      model3[pool[i]] = wd;
    end
    for (int n = 0; n < 150; n++) begin
      a = ($urandom & 32'hFFFFF000) | (32'(pool[$urandom_range(7, 0)]) << 2) | 32'($urandom_range(3, 0));
      we = 1'($urandom_range(1, 0));
      be = 4'($urandom);
      wd = $urandom;
      w = widx(a);
      if (n % 2 == 0) begin
        acc1(we, be, a, wd, rd, rv, st);
        if (we) model1[w] = merge(model1[w], wd, be);
        else last_rd1 = model1[w];
        exp = last_rd1;
        checks += 3;
        if (rd !== exp) begin errors++; $display("FAIL rnd1_rdata n=%0d got %h exp %h", n, rd, exp); end
        if (rv !== !we) begin errors++; $display("FAIL rnd1_rvalid n=%0d got %b exp %b", n, rv, !we); end
        if (st !== 1'b0) begin errors++; $display("FAIL rnd1_stall n=%0d got %b exp 0", n, st); end
      end else begin
        acc3(we, be, a, wd, rd, rv, rvn, stalls, tmo);
        if (we) model3[w] = merge(model3[w], wd, be);
        else last_rd3 = model3[w];
        exp = last_rd3;
        checks += 4;
        if (rd !== exp) begin errors++; $display("FAIL rnd3_rdata n=%0d got %h exp %h", n, rd, exp); end
        if (rv !== !we) begin errors++; $display("FAIL rnd3_rvalid n=%0d got %b exp %b", n, rv, !we); end
        if (rvn !== 1'b0) begin errors++; $display("FAIL rnd3_pulse n=%0d got %b exp 0", n, rvn); end
        if (tmo || stalls != 2) begin errors++; $display("FAIL rnd3_stalls n=%0d got %0d exp 2", n, stalls); end
      end
    end
  endtask

  initial begin
    b1.req = 1'b0; b1.memwrite = 1'b0; b1.sig_write = '0; b1.addr = '0; b1.wdata = '0;
    b3.req = 1'b0; b3.memwrite = 1'b0; b3.sig_write = '0; b3.addr = '0; b3.wdata = '0;
    rst1 = 1'b1; rst3 = 1'b1;
    test_reset();
    test_byte_enables();
    test_wrap();
    test_back_to_back();
    test_latency3();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test sequence ended");
    $fatal(1, "watchdog");
  end
endmodule
